// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, field offsets and allocator states.
package noc_pkg;

    localparam int TYPE_W            = 3;
    localparam int DEFAULT_LEN_WIDTH = 12;

    localparam logic [TYPE_W-1:0] FLIT_HEADER = 3'b001;
    localparam logic [TYPE_W-1:0] FLIT_BODY   = 3'b010;
    localparam logic [TYPE_W-1:0] FLIT_TAIL   = 3'b100;

    // Type sits in the top bits of the flit; the length field follows directly below it.
    function automatic int type_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int len_msb(input int dw);
        return dw - 1 - TYPE_W;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/noc_out_port_alloc_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or above rr_ptr, with wrap.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  winner
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(rr_ptr) + k) % N);
            if (!found && eligible[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_out_port_alloc.sv
// Per-output-port allocator: round-robin wormhole arbitration, registered RTS/DCTS link.
// Optional packet framing check enabled by defining NOC_ALLOC_TAIL_CHECK_EN.
module noc_out_port_alloc
    import noc_pkg::*;
#(
    parameter int NUM_IN     = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            req_i,
    input  logic [NUM_IN-1:0]            valid_i,
    input  logic [NUM_IN*DATA_WIDTH-1:0] flit_i,
    output logic [NUM_IN-1:0]            rd_en_o,
    output logic [NUM_IN-1:0]            grant_o,
    output logic [DATA_WIDTH-1:0]        tx_o,
    output logic                         rts_o,
    input  logic                         dcts_i,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int PW       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int TYPE_MSB = type_msb(DATA_WIDTH);
    localparam int LEN_MSB  = len_msb(DATA_WIDTH);

    alloc_state_e          state_q, state_d;
    logic [NUM_IN-1:0]     grant_q, grant_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  rts_q, rts_d;
    logic                  busy_q, busy_d;

    logic [NUM_IN-1:0]     eligible;
    logic [NUM_IN-1:0]     winner;
    logic [LEN_WIDTH-1:0]  winner_len;
    logic [DATA_WIDTH-1:0] owner_flit;
    logic                  owner_valid;
    logic [PW-1:0]         owner_idx;
    logic                  xfer;
    logic                  last;

`ifdef NOC_ALLOC_TAIL_CHECK_EN
    logic                  first_q, first_d;
    logic                  err_q, err_d;
    logic                  is_tail;
    logic                  is_header;
`endif

    // Only header flits may open a wormhole; body/tail flits at an idle head are ignored.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = req_i[i] & valid_i[i]
                        & (flit_i[i*DATA_WIDTH + TYPE_MSB -: TYPE_W] == FLIT_HEADER);
        end
    end

    rr_arbiter #(
        .N  (NUM_IN),
        .PW (PW)
    ) u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .winner   (winner)
    );

    always_comb begin
        owner_flit  = '0;
        owner_valid = 1'b0;
        owner_idx   = '0;
        winner_len  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q[i]) begin
                owner_flit  = flit_i[i*DATA_WIDTH +: DATA_WIDTH];
                owner_valid = valid_i[i];
                owner_idx   = PW'(i);
            end
            if (winner[i]) begin
                winner_len = flit_i[i*DATA_WIDTH + LEN_MSB -: LEN_WIDTH];
            end
        end
    end

    assign xfer = (state_q == ST_XFER) && owner_valid && dcts_i;

`ifdef NOC_ALLOC_TAIL_CHECK_EN
    assign is_tail   = (owner_flit[TYPE_MSB -: TYPE_W] == FLIT_TAIL);
    assign is_header = (owner_flit[TYPE_MSB -: TYPE_W] == FLIT_HEADER);
    assign last      = (cnt_q == LEN_WIDTH'(1)) || is_tail;
`else
    assign last      = (cnt_q == LEN_WIDTH'(1));
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        tx_d     = tx_q;
        rts_d    = 1'b0;
        busy_d   = busy_q;
`ifdef NOC_ALLOC_TAIL_CHECK_EN
        first_d  = first_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d = ST_XFER;
                    grant_d = winner;
                    cnt_d   = (winner_len == '0) ? LEN_WIDTH'(1) : winner_len;
                    busy_d  = 1'b1;
`ifdef NOC_ALLOC_TAIL_CHECK_EN
                    first_d = 1'b1;
`endif
                end
            end
            ST_XFER: begin
                if (xfer) begin
                    tx_d  = owner_flit;
                    rts_d = 1'b1;
                    cnt_d = cnt_q - LEN_WIDTH'(1);
`ifdef NOC_ALLOC_TAIL_CHECK_EN
                    // The opening header is exempt; later flits must agree with the count.
                    first_d = 1'b0;
                    err_d   = !first_q
                            && ((is_tail != (cnt_q == LEN_WIDTH'(1))) || is_header);
`endif
                    if (last) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b0;
                        rr_ptr_d = (owner_idx == PW'(NUM_IN - 1)) ? '0 : owner_idx + PW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            tx_q     <= '0;
            rts_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef NOC_ALLOC_TAIL_CHECK_EN
            first_q  <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            tx_q     <= tx_d;
            rts_q    <= rts_d;
            busy_q   <= busy_d;
`ifdef NOC_ALLOC_TAIL_CHECK_EN
            first_q  <= first_d;
            err_q    <= err_d;
`endif
        end
    end

    // The pop is combinational so the FIFO advances in the same cycle the flit is captured.
    assign rd_en_o = (xfer && !rst) ? grant_q : '0;
    assign grant_o = grant_q;
    assign tx_o    = tx_q;
    assign rts_o   = rts_q;
    assign busy_o  = busy_q;
`ifdef NOC_ALLOC_TAIL_CHECK_EN
    assign err_o   = err_q;
`else
    assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_port_alloc.sv
// Bench for noc_out_port_alloc: FIFO models per input, scoreboard of expected output flits.
module tb_noc_out_port_alloc;

    localparam int NI = 5;
    localparam int DW = 32;
    localparam int LW = 12;

    logic            clk;
    logic            rst;
    logic [NI-1:0]   req_i, valid_i, rd_en_o, grant_o;
    logic [NI*DW-1:0] flit_i;
    logic [DW-1:0]   tx_o;
    logic            rts_o, dcts_i, busy_o, err_o;

    noc_out_port_alloc #(.NUM_IN(NI), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .valid_i(valid_i), .flit_i(flit_i),
        .rd_en_o(rd_en_o), .grant_o(grant_o), .tx_o(tx_o), .rts_o(rts_o),
        .dcts_i(dcts_i), .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] fmem [NI][64];
    int            fhead [NI];
    int            ftail [NI];
    logic [NI-1:0] req_mask, vblock;
    logic          dcts;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pkt [16];
    int            seq = 1;

    logic [NI-1:0] s_rd, s_grant, prev_grant;
    logic          s_busy, s_rts, s_err;
    logic [DW-1:0] s_tx;
    logic [NI-1:0] glog[$];
    int            gstart[$];
    int            gend[$];
    int            err_cnt, rts_cnt, last_err_cyc;

    task automatic clear_logs();
        glog.delete(); gstart.delete(); gend.delete();
        err_cnt = 0; rts_cnt = 0; last_err_cyc = -1;
    endtask

    task automatic clear_env();
        for (int i = 0; i < NI; i++) begin fhead[i] = 0; ftail[i] = 0; end
        req_mask = '0; vblock = '0; dcts = 1'b1;
        exp_q.delete();
        clear_logs();
    endtask

    // Build a packet: header, bodies, and a TAIL on the last of n flits.
    task automatic push_pkt(input int p, input int lenf, input int n, input int nexp);
        logic [2:0]    t;
        logic [DW-1:0] f;
        for (int k = 0; k < n; k++) begin
            t = (k == 0) ? 3'b001 : ((k == n - 1) ? 3'b100 : 3'b010);
            f = {t, LW'(lenf), 17'(seq)};
            seq++;
            fmem[p][ftail[p]] = f;
            ftail[p]++;
            pkt[k] = f;
            if (k < nexp) exp_q.push_back(f);
        end
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later, then scoreboard.
    task automatic tick();
        logic [DW-1:0] e;
        for (int i = 0; i < NI; i++) begin
            if (fhead[i] != ftail[i]) begin
                valid_i[i] = !vblock[i];
                flit_i[i*DW +: DW] = fmem[i][fhead[i]];
            end else begin
                valid_i[i] = 1'b0;
                flit_i[i*DW +: DW] = '0;
            end
        end
        req_i  = req_mask;
        dcts_i = dcts;
        #1;
        s_rd = rd_en_o; s_grant = grant_o; s_busy = busy_o;
        s_rts = rts_o; s_tx = tx_o; s_err = err_o;
        if (s_rts === 1'b1) begin
            rts_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected cyc=%0d got tx=%h exp none", cyc, s_tx);
            end else begin
                e = exp_q.pop_front();
                if (s_tx !== e) begin
                    bad++;
                    $display("FAIL sb_tx cyc=%0d got=%h exp=%h", cyc, s_tx, e);
                end
            end
        end
        if (s_err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
        if (s_grant != '0 && prev_grant == '0) begin glog.push_back(s_grant); gstart.push_back(cyc); end
        if (s_grant == '0 && prev_grant != '0) gend.push_back(cyc);
        prev_grant = s_grant;
        for (int i = 0; i < NI; i++)
            if (s_rd[i] === 1'b1 && fhead[i] != ftail[i]) fhead[i]++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_drain(input int limit, input string name);
        int n;
        n = 0;
        do begin tick(); n++; end
        while ((exp_q.size() != 0 || s_busy === 1'b1 || s_rts === 1'b1) && n < limit);
        total++;
        if (exp_q.size() != 0 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain got left=%0d busy=%b exp left=0 busy=0", name, exp_q.size(), s_busy);
        end
    endtask

    task automatic do_reset();
        clear_env();
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        prev_grant = '0;
        clear_logs();
    endtask

    task automatic test_reset();
        clear_env();
        rst = 1'b1;
        tick();
        total++; if (s_rd !== '0) begin bad++; $display("FAIL reset_rd_first got=%b exp=0", s_rd); end
        tick();
        total++; if (s_grant !== '0) begin bad++; $display("FAIL reset_grant got=%b exp=0", s_grant); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
        total++; if (s_rts !== 1'b0) begin bad++; $display("FAIL reset_rts got=%b exp=0", s_rts); end
        total++; if (s_tx !== '0) begin bad++; $display("FAIL reset_tx got=%h exp=0", s_tx); end
        total++; if (s_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", s_err); end
        rst = 1'b0;
        prev_grant = '0;
    endtask

    task automatic test_single_packet();
        do_reset();
        push_pkt(2, 4, 4, 4);
        req_mask = 5'b00100;
        tick();
        total++; if (s_rd !== '0) begin bad++; $display("FAIL single_arb_rd got=%b exp=0", s_rd); end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (s_rd !== 5'b00100 || s_grant !== 5'b00100 || s_busy !== 1'b1) begin
                bad++;
                $display("FAIL single_xfer%0d got rd=%b grant=%b busy=%b exp rd=00100 grant=00100 busy=1",
                         k, s_rd, s_grant, s_busy);
            end
        end
        tick();
        total++;
        if (s_rd !== '0 || s_grant !== '0 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got rd=%b grant=%b busy=%b exp 0/0/0", s_rd, s_grant, s_busy);
        end
        tick();
        total++; if (rts_cnt != 4) begin bad++; $display("FAIL single_rts_count got=%0d exp=4", rts_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_left got=%0d exp=0", exp_q.size()); end
        // Pointer now at 3: input 3 must beat input 1.
        clear_logs();
        push_pkt(3, 2, 2, 2);
        push_pkt(1, 2, 2, 2);
        req_mask = 5'b01010;
        run_drain(40, "rrptr");
        total++;
        if (glog.size() != 2 || glog[0] !== 5'b01000) begin
            bad++;
            $display("FAIL rrptr_first got n=%0d first=%b exp n=2 first=01000", glog.size(), glog[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [NI-1:0] order [4];
        order[0] = 5'b00001; order[1] = 5'b00010; order[2] = 5'b10000; order[3] = 5'b00001;
        do_reset();
        push_pkt(0, 2, 2, 2);
        push_pkt(1, 2, 2, 2);
        push_pkt(4, 2, 2, 2);
        push_pkt(0, 2, 2, 2);
        req_mask = 5'b10011;
        run_drain(60, "rr");
        total++; if (glog.size() != 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", glog.size()); end
        for (int k = 0; k < 4 && k < glog.size(); k++) begin
            total++;
            if (glog[k] !== order[k]) begin bad++; $display("FAIL rr_order%0d got=%b exp=%b", k, glog[k], order[k]); end
        end
        for (int k = 1; k < 4 && k < gstart.size() && k <= gend.size(); k++) begin
            total++;
            if (gstart[k] - gend[k-1] != 1) begin
                bad++;
                $display("FAIL rr_gap%0d got=%0d exp=1", k, gstart[k] - gend[k-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        do_reset();
        push_pkt(2, 5, 5, 5);
        held = pkt[1];
        req_mask = 5'b00100;
        tick(); tick(); tick();
        dcts = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (s_rd !== '0 || s_tx !== held || s_grant !== 5'b00100 || (k > 0 && s_rts !== 1'b0)) begin
                bad++;
                $display("FAIL bp_stall%0d got rd=%b tx=%h rts=%b grant=%b exp rd=0 tx=%h rts=0 grant=00100",
                         k, s_rd, s_tx, s_rts, s_grant, held);
            end
        end
        dcts = 1'b1;
        run_drain(40, "bp");
        total++; if (rts_cnt != 5) begin bad++; $display("FAIL bp_rts_count got=%0d exp=5", rts_cnt); end
    endtask

    task automatic test_underflow_nonheader();
        do_reset();
        fmem[1][0] = {3'b010, LW'(1), 17'h1ABCD};
        ftail[1] = 1;
        push_pkt(0, 4, 4, 4);
        push_pkt(3, 2, 2, 2);
        req_mask = 5'b01011;
        tick(); tick();
        vblock[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (s_rd !== '0 || s_grant !== 5'b00001) begin
                bad++;
                $display("FAIL uf_stall%0d got rd=%b grant=%b exp rd=0 grant=00001", k, s_rd, s_grant);
            end
        end
        vblock[0] = 1'b0;
        run_drain(40, "uf");
        total++;
        if (glog.size() != 2 || glog[0] !== 5'b00001 || glog[1] !== 5'b01000) begin
            bad++;
            $display("FAIL uf_order got n=%0d g0=%b g1=%b exp n=2 g0=00001 g1=01000", glog.size(), glog[0], glog[1]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (s_grant !== '0 || s_rd !== '0) begin
                bad++;
                $display("FAIL body_never_granted%0d got grant=%b rd=%b exp 0/0", k, s_grant, s_rd);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int rd_seen;
        int n;
        do_reset();
        push_pkt(2, 1, 1, 1);
        req_mask = 5'b00100;
        run_drain(20, "rm_pre");
        push_pkt(2, 5, 5, 2);
        rd_seen = 0; n = 0;
        while (rd_seen < 2 && n < 20) begin
            tick();
            if (s_rd != '0) rd_seen++;
            n++;
        end
        total++; if (rd_seen != 2) begin bad++; $display("FAIL rm_wait got=%0d exp=2", rd_seen); end
        rst = 1'b1;
        tick();
        total++; if (s_rd !== '0) begin bad++; $display("FAIL rm_rd_in_reset got=%b exp=0", s_rd); end
        rst = 1'b0;
        fhead[2] = 0; ftail[2] = 0;
        req_mask = '0;
        tick();
        total++;
        if (s_grant !== '0 || s_busy !== 1'b0 || s_rts !== 1'b0 || s_tx !== '0 || s_rd !== '0 || s_err !== 1'b0) begin
            bad++;
            $display("FAIL rm_outputs got grant=%b busy=%b rts=%b tx=%h rd=%b err=%b exp all 0",
                     s_grant, s_busy, s_rts, s_tx, s_rd, s_err);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rm_partial got left=%0d exp=0", exp_q.size()); end
        clear_logs();
        push_pkt(1, 3, 3, 3);
        push_pkt(4, 2, 2, 2);
        req_mask = 5'b10010;
        run_drain(40, "rm_post");
        total++;
        if (glog.size() != 2 || glog[0] !== 5'b00010) begin
            bad++;
            $display("FAIL rm_ptr_zero got n=%0d first=%b exp n=2 first=00010", glog.size(), glog[0]);
        end
    endtask

    task automatic test_tail_check();
        do_reset();
`ifdef NOC_ALLOC_TAIL_CHECK_EN
        push_pkt(2, 5, 3, 3);
        push_pkt(2, 5, 5, 5);
        req_mask = 5'b00100;
        run_drain(40, "tail");
        total++;
        if (gstart.size() != 2 || gend.size() != 2 || gend[0] - gstart[0] != 3 || gend[1] - gstart[1] != 5) begin
            bad++;
            $display("FAIL tail_len got n=%0d d0=%0d d1=%0d exp n=2 d0=3 d1=5",
                     gstart.size(), gend[0] - gstart[0], gend[1] - gstart[1]);
        end
        total++; if (err_cnt != 1) begin bad++; $display("FAIL tail_err_count got=%0d exp=1", err_cnt); end
        total++;
        if (gend.size() < 1 || last_err_cyc != gend[0]) begin
            bad++;
            $display("FAIL tail_err_cycle got=%0d exp=%0d", last_err_cyc, gend[0]);
        end
`else
        push_pkt(2, 3, 3, 3);
        req_mask = 5'b00100;
        run_drain(30, "notail");
        total++;
        if (gstart.size() != 1 || gend.size() != 1 || gend[0] - gstart[0] != 3) begin
            bad++;
            $display("FAIL notail_len got n=%0d d=%0d exp n=1 d=3", gstart.size(), gend[0] - gstart[0]);
        end
        total++; if (err_cnt != 0) begin bad++; $display("FAIL notail_err got=%0d exp=0", err_cnt); end
`endif
    endtask

    initial begin
        rst = 1'b1; req_i = '0; valid_i = '0; flit_i = '0; dcts_i = 1'b1;
        prev_grant = '0;
        clear_env();
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_underflow_nonheader();
        test_reset_mid_packet();
        test_tail_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/noc_out_port_alloc.md
# noc_out_port_alloc

Parametrised output-port allocator for the mesh router. It replaces the fixed per-port arbiter, crossbar and output-buffer trio with one block per output port. The port count, flit width and length-field width are all parameters. The block arbitrates among `NUM_IN` input FIFOs using round-robin and holds a wormhole lock for a whole packet. It drives one registered output link using the RTS/DCTS handshake. One instance sits at each output port (N/E/W/S/L); corner routers simply instantiate fewer.

## Interface
Parameters:
- `NUM_IN`, 5: number of input ports competing for this output.
- `DATA_WIDTH`, 32: flit width.
- `LEN_WIDTH`, 12: packet-length field width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, **synchronous and active-high**.
- `req_i` in `NUM_IN`: input i is routed to this output and downstream is ready (LBDR + flowcontrol result).
- `valid_i` in `NUM_IN`: input i's FIFO is non-empty.
- `flit_i` in `NUM_IN*DATA_WIDTH`: head flit of each input FIFO; input i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `rd_en_o` out `NUM_IN`: one-hot pop to the owner FIFO; combinational.
- `grant_o` out `NUM_IN`: one-hot current owner; all-zero when idle.
- `tx_o` out `DATA_WIDTH`: registered output flit.
- `rts_o` out 1: registered request-to-send to the next router or NI.
- `dcts_i` in 1: clear-to-send from the next router or NI.
- `busy_o` out 1: high in XFER.
- `err_o` out 1: packet framing error pulse. Tied to 0 unless the macro is defined.

## Operation
Flit fields:
- type `[DW-1:DW-3]`: HEADER=3'b001, BODY=3'b010, TAIL=3'b100.
- length `[DW-4:DW-3-LEN_WIDTH]`: total flits including the header.

State machine:
- **IDLE**:
  - Eligible inputs are those with `req_i[i] & valid_i[i] & type==HEADER`.
  - If none are eligible, stay in IDLE.
  - Otherwise pick the first eligible input scanning from `rr_ptr` upward, with wrap-around.
  - Register it as the owner and load `cnt` = length. A length of 0 is treated as 1.
  - Go to XFER.
  - Non-header flits at a FIFO head are never granted.
- **XFER**:
  - A transfer occurs in a cycle where `valid_i[owner] & dcts_i`. In that cycle `rd_en_o[owner]=1` and `cnt` decrements.
  - `req_i[owner]` is ignored once locked.
  - On the transfer with `cnt==1`: go to IDLE and set `rr_ptr` = (owner+1) mod `NUM_IN`.
- **Stall**: if `valid_i[owner]` is low or `dcts_i` is low, there is no pop, no decrement, and `tx_o` holds its value.
- **Output register**: each transfer loads `tx_o` with the owner's flit at the next edge.

Reset (any cycle, including mid-packet):
- State goes to IDLE, `rr_ptr`=0, `cnt`=0.
- `tx_o`=0, `rts_o`=0, `grant_o`=0, `busy_o`=0, `err_o`=0.
- `rd_en_o` is 0 in the reset cycle.
- A partially sent packet is abandoned; upstream is expected to be reset too.

## Timing
- Arbitration takes 1 cycle: the header is first popped in the cycle after IDLE grants.
- `rd_en_o` asserts in the transfer cycle. `tx_o` is valid and `rts_o=1` in the following cycle. `rts_o` is a single-cycle pulse per flit.
- Throughput is 1 flit per cycle while unstalled.
- Consecutive packets on the same output have exactly one IDLE cycle between them, so an L-flit packet occupies at least L+1 cycles.
- `grant_o` and `busy_o` are registered and change on the edge entering or leaving XFER.

## Configuration
- Macro `NOC_ALLOC_TAIL_CHECK_EN`.
- **Defined**:
  - The packet also ends on a transferred TAIL-type flit, whichever of TAIL or `cnt==1` comes first.
  - `err_o` pulses for 1 cycle, registered with the transfer, when they disagree: a TAIL with `cnt!=1`, or `cnt==1` on a non-TAIL flit. A header-only packet (length 1) is exempt.
  - `err_o` also pulses if a HEADER arrives from the owner while in XFER. That flit is still forwarded.
- **Undefined**: termination is by length count only, and `err_o` is tied to 0.

## Structure
- Shared package `noc_pkg`:
  - Flit type constants HEADER/BODY/TAIL.
  - Field offsets for type and length.
  - The default `LEN_WIDTH`.
- Sub-module `rr_arbiter` (parameter N): inputs are an eligible vector and `rr_ptr`; output is a one-hot winner. It is purely combinational.
- The FSM, counter, output register and data mux stay in `noc_out_port_alloc`.

## Test plan
- **Single packet**: `NUM_IN`=5, input 2 presents a header with length 4 followed by 3 flits, `dcts_i`=1.
  - `rd_en_o`=5'b00100 for 4 consecutive cycles starting 1 cycle after the request.
  - `tx_o` sequence matches the input flits, with 4 `rts_o` pulses.
  - Returns to IDLE, `rr_ptr`=3.
- **Round-robin**: inputs 0, 1 and 4 all request with length-2 packets from reset.
  - Grant order is 0, 1, 4, then 0 again if 0 re-requests.
  - Exactly one idle cycle between packets.
- **Backpressure**: drop `dcts_i` for 3 cycles mid-packet.
  - No `rd_en_o` and no `rts_o` during the stall; `tx_o` held.
  - `cnt` resumes and the packet completes intact.
- **Underflow stall and non-header**:
  - Owner `valid_i` drops for 2 cycles: the lock is held, and a competing header on input 3 is not granted until the packet ends.
  - A BODY flit at the head of an idle input is never granted.
- **Reset mid-packet**: assert `rst` after 2 of 5 flits.
  - Next cycle: all outputs 0, IDLE, `rr_ptr`=0.
  - A new header on input 1 is granted normally.
- **With `NOC_ALLOC_TAIL_CHECK_EN`**:
  - Length 5 with a TAIL on flit 3: the packet ends after flit 3 and `err_o` pulses once.
  - A correct length-5 packet gives `err_o`=0.
